// File: rtl/pio_pkg.sv
// Shared definitions for the input PIO: Avalon word addresses and edge-select encodings.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_DIR  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Per-bit edge qualifier for the selected edge type.
  function automatic logic edge_hit(input int unsigned etype, input logic prev, input logic cur);
    logic hit;
    hit = 1'b0;
    if (etype == EDGE_RISE)      hit = ~prev & cur;
    else if (etype == EDGE_FALL) hit = prev & ~cur;
    else                         hit = prev ^ cur;
    return hit;
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: two-flop synchronizer followed by a stable-count debouncer.
module pio_debounce
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter logic        RESET_VAL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_deb  <= RESET_VAL;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      // Any cycle where the synchronized input agrees with the output restarts the count.
      if (r_sync != r_deb) begin
        if (r_cnt == CNT_LAST) begin
          r_deb <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/pio_input_capture.sv
// Input PIO: per-bit debounce, sticky edge capture, masked level irq, Avalon-MM slave.
module pio_input_capture
  import pio_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       DEBOUNCE_CYC = 50000,
  parameter int unsigned       EDGE_TYPE    = EDGE_RISE,
  parameter logic [WIDTH-1:0]  IN_RESET_VAL = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] in_port_export,
  input  logic [1:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_mask_next;
  logic [WIDTH-1:0] w_capture_next;
  logic [31:0]      w_rdata_next;
  logic             w_wr_sel;
  logic             w_rd_sel;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_capture;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RESET_VAL    (IN_RESET_VAL[g])
    ) u_debounce (
      .i_clk   (clk_clk),
      .i_rst_n (reset_reset_n),
      .i_raw   (in_port_export[g]),
      .o_deb   (w_deb[g])
    );
  end

  assign w_wr_sel       = avs_chipselect & avs_write;
  assign w_rd_sel       = avs_chipselect & avs_read;
  assign w_unused_wdata = ^avs_writedata;

  always_comb begin
    w_edge = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_edge[i] = edge_hit(EDGE_TYPE, r_prev[i], w_deb[i]);
    end
  end

  always_comb begin
    w_clr       = '0;
    w_mask_next = r_mask;
    if (w_wr_sel) begin
      if (pio_addr_e'(avs_address) == ADDR_EDGE) w_clr       = avs_writedata[WIDTH-1:0];
      if (pio_addr_e'(avs_address) == ADDR_MASK) w_mask_next = avs_writedata[WIDTH-1:0];
    end
    // Set is OR-ed after the clear so a same-cycle edge survives the clear.
    w_capture_next = (r_capture & ~w_clr) | w_edge;
  end

  always_comb begin
    w_rdata_next = '0;
    if (w_rd_sel) begin
      case (pio_addr_e'(avs_address))
        ADDR_DATA: w_rdata_next[WIDTH-1:0] = w_deb;
        ADDR_DIR:  w_rdata_next            = '0;
        ADDR_MASK: w_rdata_next[WIDTH-1:0] = r_mask;
        ADDR_EDGE: w_rdata_next[WIDTH-1:0] = r_capture;
        default:   w_rdata_next            = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_prev       <= IN_RESET_VAL;
      r_mask       <= '0;
      r_capture    <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      r_prev       <= w_deb;
      r_mask       <= w_mask_next;
      r_capture    <= w_capture_next;
      avs_readdata <= w_rdata_next;
      irq          <= |(w_capture_next & w_mask_next);
    end
  end

endmodule

// File: tb/tb_pio_input_capture.sv
// Bench for pio_input_capture: three edge-type instances on shared stimulus, checked against a window model.
module tb_pio_input_capture;

  localparam int unsigned W  = 8;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  raw;
  logic [1:0]    addr;
  logic          cs, rd, wr;
  logic [31:0]   wdata;
  logic [31:0]   dut_rd  [3];
  logic          dut_irq [3];

  always #5 clk = ~clk;

  pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYC(DC), .EDGE_TYPE(0)) u_dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_port_export(raw), .avs_address(addr),
    .avs_chipselect(cs), .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(dut_rd[0]), .irq(dut_irq[0]));

  pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYC(DC), .EDGE_TYPE(1)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_port_export(raw), .avs_address(addr),
    .avs_chipselect(cs), .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(dut_rd[1]), .irq(dut_irq[1]));

  pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYC(DC), .EDGE_TYPE(2)) u_dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_port_export(raw), .avs_address(addr),
    .avs_chipselect(cs), .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
    .avs_readdata(dut_rd[2]), .irq(dut_irq[2]));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Model: raw samples history (newest first), debounced value, previous, mask, per-type capture/irq/readdata.
  logic [W-1:0]  q [$];
  logic [W-1:0]  m_deb, m_prev, m_mask;
  logic [W-1:0]  m_ec  [3];
  logic          m_irq [3];
  logic [31:0]   m_rd  [3];

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < DC + 2; k++) q.push_back('0);
    m_deb = '0; m_prev = '0; m_mask = '0;
    for (int t = 0; t < 3; t++) begin
      m_ec[t] = '0; m_irq[t] = 1'b0; m_rd[t] = '0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] edges [3];
    logic [W-1:0] clr, mask_n, nxt;
    logic         flip;
    q.push_front(raw);
    q.delete(q.size() - 1);
    edges[0] = ~m_prev & m_deb;
    edges[1] = m_prev & ~m_deb;
    edges[2] = m_prev ^ m_deb;
    clr    = (cs && wr && addr == 2'd3) ? wdata[W-1:0] : '0;
    mask_n = (cs && wr && addr == 2'd2) ? wdata[W-1:0] : m_mask;
    for (int t = 0; t < 3; t++) begin
      m_rd[t] = '0;
      if (cs && rd) begin
        case (addr)
          2'd0: m_rd[t] = 32'(m_deb);
          2'd2: m_rd[t] = 32'(m_mask);
          2'd3: m_rd[t] = 32'(m_ec[t]);
          default: m_rd[t] = '0;
        endcase
      end
      nxt      = (m_ec[t] & ~clr) | edges[t];
      m_irq[t] = |(nxt & mask_n);
      m_ec[t]  = nxt;
    end
    m_mask = mask_n;
    m_prev = m_deb;
    // A bit flips once the synchronized input (two samples late) has disagreed for DC samples in a row.
    for (int b = 0; b < W; b++) begin
      flip = 1'b1;
      for (int k = 2; k < DC + 2; k++) if (q[k][b] == m_deb[b]) flip = 1'b0;
      if (flip) m_deb[b] = ~m_deb[b];
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      check_eq($sformatf("rdata_t%0d", t), dut_rd[t], m_rd[t]);
      check_eq($sformatf("irq_t%0d", t), 32'(dut_irq[t]), 32'(m_irq[t]));
    end
  endtask

  task automatic idle(input int n);
    cs = 0; rd = 0; wr = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; wdata = d;
    cycle();
    cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    cs = 1; rd = 1; wr = 0; addr = a;
    cycle();
    cs = 0; rd = 0;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2);
    check_eq({tag, "_t0"}, dut_rd[0], e0);
    check_eq({tag, "_t1"}, dut_rd[1], e1);
    check_eq({tag, "_t2"}, dut_rd[2], e2);
  endtask

  initial begin
    rst_n = 0; raw = '0; addr = '0; cs = 0; rd = 0; wr = 0; wdata = '0;
    model_reset();
    @(negedge clk);

    // Reset held with toggling inputs and an active read strobe.
    for (int i = 0; i < 5; i++) begin
      raw = W'($urandom); cs = 1; rd = 1; addr = 2'($urandom);
      cycle();
      for (int t = 0; t < 3; t++) begin
        check_eq("rst_rdata", dut_rd[t], 32'h0);
        check_eq("rst_irq", 32'(dut_irq[t]), 32'h0);
      end
    end
    cs = 0; rd = 0; raw = '0;
    rst_n = 1;
    bus_read(2'd2); expect_all("mask_after_rst", 0, 0, 0);
    bus_read(2'd3); expect_all("edge_after_rst", 0, 0, 0);

    // Debounce latency: data visible on readdata the cycle after debounced changes.
    raw = 8'h01; cs = 1; rd = 1; addr = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      check_eq($sformatf("deb_latency_k%0d", k), dut_rd[0], (k == 7) ? 32'h1 : 32'h0);
    end
    cs = 0; rd = 0;
    raw = 8'h03; idle(3); raw = 8'h01;
    cs = 1; rd = 1; addr = 2'd0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check_eq("glitch_bit1", dut_rd[0], 32'h1);
    end
    cs = 0; rd = 0;

    // Capture and irq.
    raw = 8'h00; idle(8);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h01);
    raw = 8'h01; idle(8);
    check_eq("irq_rise_b0", 32'(dut_irq[0]), 32'h1);
    bus_read(2'd3); check_eq("ec_rise_b0", dut_rd[0], 32'h01);
    raw = 8'h05; idle(8);
    check_eq("irq_rise_b2", 32'(dut_irq[0]), 32'h1);
    bus_read(2'd3); check_eq("ec_rise_b2", dut_rd[0], 32'h05);

    // Clear racing a new bit-0 capture: set wins.
    raw = 8'h04; idle(8);
    raw = 8'h05; idle(6);
    bus_write(2'd3, 32'h01);
    check_eq("race_irq", 32'(dut_irq[0]), 32'h1);
    bus_read(2'd3); check_eq("race_ec", dut_rd[0], 32'h05);
    bus_write(2'd3, 32'h01);
    check_eq("clear_irq", 32'(dut_irq[0]), 32'h0);
    bus_read(2'd3); check_eq("clear_ec", dut_rd[0], 32'h04);

    // Edge type selection on bit 3.
    bus_write(2'd3, 32'hFF);
    raw = 8'h0D; idle(8);
    bus_read(2'd3); expect_all("rise_b3", 32'h08, 32'h00, 32'h08);
    bus_write(2'd3, 32'hFF);
    raw = 8'h05; idle(8);
    bus_read(2'd3); expect_all("fall_b3", 32'h00, 32'h08, 32'h08);

    // Bus register behaviour.
    bus_read(2'd1);                    expect_all("dir_read", 0, 0, 0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0);                    expect_all("data_ro", 32'h05, 32'h05, 32'h05);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1);                    expect_all("dir_ro", 0, 0, 0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2);                    expect_all("mask_rb", 32'hFF, 32'hFF, 32'hFF);

    // Random traffic, with one reset in the middle of activity.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 0;
        model_reset();
        cycle(); cycle();
        rst_n = 1;
      end
      if ($urandom_range(7) == 0) raw = raw ^ W'(1 << $urandom_range(W - 1));
      if ($urandom_range(1) == 0) begin
        cs = ($urandom_range(3) != 0);
        rd = $urandom_range(1) == 1;
        wr = ($urandom_range(3) == 0);
        addr = 2'($urandom);
        wdata = $urandom;
      end else begin
        cs = 0; rd = 0; wr = 0;
      end
      cycle();
    end
    cs = 0; rd = 0; wr = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
